// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register indices, reset constants and the
// decoded write-back index record used by the register bank.
package cpu_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NREGS_DEF = 32;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd31;

  localparam logic [31:0] SP_RESET_DEF = 32'd227;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [31:0]          word_t;

  // Decoded destination index coming out of wb_idx_check.
  typedef struct packed {
    reg_idx_t idx;
    logic     valid;
    logic     is_zero;
  } wb_idx_t;

endpackage

// File: rtl/wb_idx_check.sv
// Decodes the 32-bit destination select from the write-register mux into a
// 5-bit register index, flagging out-of-range or unknown selects.
module wb_idx_check
  import cpu_pkg::*;
(
  input  word_t   wr_index,
  output wb_idx_t info
);

  // Upper bits must be clean zeros; any X/Z anywhere makes the index unusable.
  always_comb begin
    // NOTE: every field gets a value on every path so no latch is inferred.
    info.idx     = wr_index[REG_IDX_W-1:0];
    info.valid   = (wr_index[31:REG_IDX_W] == '0) && !$isunknown(wr_index);
    info.is_zero = (wr_index[REG_IDX_W-1:0] == REG_ZERO);
  end

endmodule

// File: rtl/banco_reg_wb.sv
// 32x32 general-purpose register bank at the write-back stage.
// Two combinational read ports with optional same-cycle forwarding of the
// write in flight, a sticky bad-index flag and a saturating write counter.
module banco_reg_wb
  import cpu_pkg::*;
#(
  parameter logic [31:0] SP_RESET  = SP_RESET_DEF,
  parameter bit          BYPASS_EN = 1'b1,
  parameter int          NREGS     = NREGS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic [31:0] WriteReg,
  input  logic [31:0] WriteData,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic        IdxErr,
  output logic [15:0] WrCount
);

  word_t   regs [NREGS];
  wb_idx_t wb;
  logic    fwd_ok;

  wb_idx_check u_idx_check (
    .wr_index (WriteReg),
    .info     (wb)
  );

  // A write is forwardable only if it will actually land in the array.
  assign fwd_ok = BYPASS_EN && RegWrite && !reset && wb.valid && !wb.is_zero;

  // Array update, error flag and commit counter; reset dominates any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the whole array is reset because $sp must come up at SP_RESET
      // and software relies on the others reading as zero.
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
      end
      IdxErr  <= 1'b0;
      WrCount <= '0;
    end else if (RegWrite) begin
      if (wb.valid) begin
        // NOTE: non-blocking so reads this cycle still see the old contents.
        if (!wb.is_zero) regs[wb.idx] <= WriteData;
        if (WrCount != 16'hFFFF) WrCount <= WrCount + 16'd1;
      end else begin
        IdxErr <= 1'b1;
      end
    end
  end

  // Port 1: $zero is constant, otherwise forward the in-flight write or read the array.
  always_comb begin
    ReadData1 = regs[ReadReg1];
    if (ReadReg1 == REG_ZERO)                ReadData1 = '0;
    else if (fwd_ok && wb.idx == ReadReg1)   ReadData1 = WriteData;
  end

  // Port 2: same selection as port 1.
  always_comb begin
    ReadData2 = regs[ReadReg2];
    if (ReadReg2 == REG_ZERO)                ReadData2 = '0;
    else if (fwd_ok && wb.idx == ReadReg2)   ReadData2 = WriteData;
  end

endmodule
